// File: rtl/ct_biu_l2c_csr_apb_bridge.sv
// ct_biu_l2c_csr_apb_bridge: pad-side L2C CSR request to APB bridge.
// One APB transfer per sel assertion; completion pulse plus 128-bit response.
module ct_biu_l2c_csr_apb_bridge #(
  parameter int ADDR_W      = 15,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              coreclk,
  input  logic              cpurst,
  input  logic              biu_pad_csr_sel,
  input  logic [79:0]       biu_pad_csr_wdata,
  output logic              pad_biu_csr_cmplt,
  output logic [127:0]      pad_biu_csr_rdata,
  output logic              l2c_psel,
  output logic              l2c_penable,
  output logic              l2c_pwrite,
  output logic [ADDR_W-1:0] l2c_paddr,
  output logic [63:0]       l2c_pwdata,
  input  logic [63:0]       l2c_prdata,
  input  logic              l2c_pready,
  input  logic              l2c_pslverr,
  output logic              bridge_busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    DROP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [15:0] req_op;
  logic [63:0] req_wd;
  logic [14:0] req_addr;
  logic        cnt_last;
  logic [63:0] rd_data;

  assign req_op   = biu_pad_csr_wdata[79:64];
  assign req_wd   = biu_pad_csr_wdata[63:0];
  assign req_addr = {req_op[11:0], 3'b000};
  assign cnt_last = (cnt == CNT_LAST);
  assign rd_data  = l2c_pwrite ? 64'd0 : l2c_prdata;

  logic unused_op;
  assign unused_op = ^req_op[14:12];

  // Bridge FSM; every output is a flop updated on the transition.
  always_ff @(posedge coreclk) begin
    if (cpurst) begin
      state             <= IDLE;
      cnt               <= '0;
      l2c_psel          <= 1'b0;
      l2c_penable       <= 1'b0;
      l2c_pwrite        <= 1'b0;
      l2c_paddr         <= '0;
      l2c_pwdata        <= '0;
      pad_biu_csr_cmplt <= 1'b0;
      pad_biu_csr_rdata <= '0;
      bridge_busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (biu_pad_csr_sel) begin
            l2c_pwrite  <= req_op[15];
            l2c_paddr   <= ADDR_W'(req_addr);
            l2c_pwdata  <= req_wd;
            l2c_psel    <= 1'b1;
            l2c_penable <= 1'b0;
            bridge_busy <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          l2c_penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (l2c_pready) begin
            pad_biu_csr_rdata <= {62'd0, 1'b0,
                                  l2c_pslverr, rd_data};
            pad_biu_csr_cmplt <= 1'b1;
            l2c_psel          <= 1'b0;
            l2c_penable       <= 1'b0;
            state             <= RESP;
          end else if (cnt_last) begin
            pad_biu_csr_rdata <= {62'd0, 1'b1,
                                  1'b0, 64'd0};
            pad_biu_csr_cmplt <= 1'b1;
            l2c_psel          <= 1'b0;
            l2c_penable       <= 1'b0;
            state             <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          pad_biu_csr_cmplt <= 1'b0;
          cnt               <= '0;
          state             <= DROP;
        end
        DROP: begin
          if (!biu_pad_csr_sel) begin
            bridge_busy <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          l2c_psel          <= 1'b0;
          l2c_penable       <= 1'b0;
          pad_biu_csr_cmplt <= 1'b0;
          bridge_busy       <= 1'b0;
          cnt               <= '0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_biu_l2c_csr_apb_bridge.sv
// tb_ct_biu_l2c_csr_apb_bridge: directed checks of the CSR APB bridge.
// Small timeout (4) keeps the timeout scenarios short.
module tb_ct_biu_l2c_csr_apb_bridge;

  logic         coreclk = 1'b0;
  logic         cpurst;
  logic         sel;
  logic [79:0]  wdata;
  logic         cmplt;
  logic [127:0] rdata;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [14:0]  paddr;
  logic [63:0]  pwdata;
  logic [63:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic         busy;

  int checks = 0;
  int failures = 0;

  ct_biu_l2c_csr_apb_bridge #(
    .ADDR_W(15), .CNT_W(8), .TIMEOUT_CYC(4)
  ) dut (
    .coreclk(coreclk),
    .cpurst(cpurst),
    .biu_pad_csr_sel(sel),
    .biu_pad_csr_wdata(wdata),
    .pad_biu_csr_cmplt(cmplt),
    .pad_biu_csr_rdata(rdata),
    .l2c_psel(psel),
    .l2c_penable(penable),
    .l2c_pwrite(pwrite),
    .l2c_paddr(paddr),
    .l2c_pwdata(pwdata),
    .l2c_prdata(prdata),
    .l2c_pready(pready),
    .l2c_pslverr(pslverr),
    .bridge_busy(busy)
  );

  always #5 coreclk = ~coreclk;

  task automatic tick();
    @(posedge coreclk);
    #1;
  endtask

  // Drives one request; pready stays low for 'waits' ACCESS cycles.
  task automatic do_txn(input logic [15:0] op,
                        input logic [63:0] wd,
                        input int waits,
                        input logic err,
                        input logic [63:0] rd,
                        output int lat,
                        output int acc,
                        output int nxfer);
    sel = 1'b1;
    wdata = {op, wd};
    pready = 1'b0;
    pslverr = err;
    prdata = rd;
    lat = 0;
    acc = 0;
    nxfer = 0;
    while (lat < 40 && !cmplt) begin
      tick();
      lat++;
      if (psel && !penable) nxfer++;
      if (penable) begin
        pready = (acc >= waits);
        acc++;
      end
    end
    pready = 1'b0;
    pslverr = 1'b0;
    checks++;
    if (cmplt !== 1'b1) begin
      failures++;
      $display("FAIL cmplt_timeout got=%b exp=1", cmplt);
    end
  endtask

  task automatic release_sel();
    sel = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    cpurst = 1'b1;
    sel = 1'b0;
    wdata = '0;
    prdata = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    tick();
    tick();
    checks++;
    if ({psel, penable, pwrite, cmplt, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=00000",
               {psel, penable, pwrite, cmplt, busy});
    end
    checks++;
    if ({paddr, pwdata, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0",
               paddr, pwdata, rdata);
    end
    cpurst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_read();
    sel = 1'b1;
    wdata = {16'h0005, 64'h0};
    pready = 1'b1;
    prdata = 64'hDEAD_BEEF_0123_4567;
    tick();
    checks++;
    if ({psel, penable, busy, cmplt} !== 4'b1010) begin
      failures++;
      $display("FAIL rd_setup got=%b exp=1010",
               {psel, penable, busy, cmplt});
    end
    checks++;
    if (paddr !== 15'h28 || pwrite !== 1'b0) begin
      failures++;
      $display("FAIL rd_addr got=%h/%b exp=28/0", paddr, pwrite);
    end
    tick();
    checks++;
    if ({psel, penable, cmplt} !== 3'b110) begin
      failures++;
      $display("FAIL rd_access got=%b exp=110",
               {psel, penable, cmplt});
    end
    tick();
    checks++;
    if ({psel, penable, cmplt} !== 3'b001) begin
      failures++;
      $display("FAIL rd_cmplt got=%b exp=001",
               {psel, penable, cmplt});
    end
    checks++;
    if (rdata !== {64'h0, 64'hDEAD_BEEF_0123_4567}) begin
      failures++;
      $display("FAIL rd_data got=%h exp=%h", rdata,
               {64'h0, 64'hDEAD_BEEF_0123_4567});
    end
    pready = 1'b0;
    prdata = 64'h0;
    sel = 1'b0;
    tick();
    checks++;
    if (cmplt !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rd_pulse got=%b%b exp=01", cmplt, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 ||
        rdata[63:0] !== 64'hDEAD_BEEF_0123_4567) begin
      failures++;
      $display("FAIL rd_idle got=%b/%h exp=0/deadbeef01234567",
               busy, rdata[63:0]);
    end
  endtask

  task automatic test_write_wait();
    int lat, acc, nx;
    do_txn(16'h8010, 64'h1, 2, 1'b0, 64'hFFFF_0000_FFFF_0000,
           lat, acc, nx);
    checks++;
    if (lat !== 5 || acc !== 3) begin
      failures++;
      $display("FAIL wr_latency got=%0d/%0d exp=5/3", lat, acc);
    end
    checks++;
    if (pwrite !== 1'b1 || pwdata !== 64'h1 ||
        paddr !== 15'h80) begin
      failures++;
      $display("FAIL wr_bus got=%b/%h/%h exp=1/1/80",
               pwrite, pwdata, paddr);
    end
    checks++;
    if (rdata !== 128'h0) begin
      failures++;
      $display("FAIL wr_rdata got=%h exp=0", rdata);
    end
    release_sel();
    checks++;
    if (pwdata !== 64'h1 || psel !== 1'b0) begin
      failures++;
      $display("FAIL wr_hold got=%h/%b exp=1/0", pwdata, psel);
    end
  endtask

  task automatic test_slverr();
    int lat, acc, nx;
    do_txn(16'h0003, 64'h0, 0, 1'b1, 64'h1234,
           lat, acc, nx);
    checks++;
    if (rdata[65:64] !== 2'b01 || rdata[63:0] !== 64'h1234 ||
        rdata[127:66] !== 62'h0) begin
      failures++;
      $display("FAIL slverr got=%h exp=1_0000000000001234", rdata);
    end
    release_sel();
  endtask

  task automatic test_timeout();
    int lat, acc, nx;
    do_txn(16'h0001, 64'h0, 100, 1'b1, 64'hAAAA, lat, acc, nx);
    checks++;
    if (acc !== 4 || lat !== 6) begin
      failures++;
      $display("FAIL to_cycles got=%0d/%0d exp=4/6", acc, lat);
    end
    checks++;
    if (rdata !== {62'h0, 2'b10, 64'h0}) begin
      failures++;
      $display("FAIL to_rdata got=%h exp=2_0000000000000000", rdata);
    end
    release_sel();
    do_txn(16'h0001, 64'h0, 3, 1'b0, 64'h5555, lat, acc, nx);
    checks++;
    if (acc !== 4 || rdata !== {64'h0, 64'h5555}) begin
      failures++;
      $display("FAIL to_edge got=%0d/%h exp=4/5555", acc, rdata);
    end
    release_sel();
  endtask

  task automatic test_back_to_back();
    int lat, acc, nx, extra, pulses;
    do_txn(16'h0002, 64'h0, 0, 1'b0, 64'h77, lat, acc, nx);
    checks++;
    if (nx !== 1) begin
      failures++;
      $display("FAIL held_first got=%0d exp=1", nx);
    end
    extra = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (psel) extra++;
      if (cmplt) pulses++;
    end
    checks++;
    if (extra !== 0 || pulses !== 0) begin
      failures++;
      $display("FAIL held_sel got=%0d/%0d exp=0/0", extra, pulses);
    end
    sel = 1'b0;
    tick();
    sel = 1'b1;
    pready = 1'b1;
    prdata = 64'h99;
    tick();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b0) begin
      failures++;
      $display("FAIL b2b_setup got=%b%b exp=10", psel, penable);
    end
    tick();
    tick();
    checks++;
    if (cmplt !== 1'b1 || rdata[63:0] !== 64'h99) begin
      failures++;
      $display("FAIL b2b_cmplt got=%b/%h exp=1/99",
               cmplt, rdata[63:0]);
    end
    pready = 1'b0;
    release_sel();
  endtask

  task automatic test_reset_mid();
    int pulses;
    sel = 1'b1;
    wdata = {16'h0007, 64'h0};
    pready = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (penable !== 1'b1) begin
      failures++;
      $display("FAIL mid_access got=%b exp=1", penable);
    end
    cpurst = 1'b1;
    sel = 1'b0;
    tick();
    checks++;
    if ({psel, penable, cmplt, busy, pwrite} !== 5'b0 ||
        paddr !== 15'h0 || rdata !== 128'h0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%h/%h exp=0/0/0",
               {psel, penable, cmplt, busy, pwrite}, paddr, rdata);
    end
    pulses = 0;
    cpurst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cmplt || psel) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL mid_nocmplt got=%0d exp=0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
